// File: rtl/mem_dma_engine.sv
// rtl/mem_dma_engine.sv - block COPY/FILL initiator for a single-port word memory
// Walks forward one word at a time: COPY alternates READ/WRITE, FILL issues a write every cycle.
module mem_dma_engine #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W:0]   len,
   input  logic [DATA_W-1:0] fill_value,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   words_done,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              mode_q;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [ADDR_W:0]   remaining;
   logic [DATA_W-1:0] fill_q;
   logic [DATA_W-1:0] rd_buf;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The last write is the one issued while remaining is still 1.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (len == '0) begin
                  state_nxt = S_DONE;
               end else if (mode) begin
                  state_nxt = S_WRITE;
               end else begin
                  state_nxt = S_READ;
               end
            end
         end
         S_READ: begin
            state_nxt = abort ? S_IDLE : S_WRITE;
         end
         S_WRITE: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (remaining == (ADDR_W+1)'(1)) begin
               state_nxt = S_DONE;
            end else if (mode_q) begin
               state_nxt = S_WRITE;
            end else begin
               state_nxt = S_READ;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         S_READ: begin
            busy     = 1'b1;
            mem_addr = src_ptr;
         end
         S_WRITE: begin
            busy      = 1'b1;
            mem_addr  = dst_ptr;
            mem_wdata = mode_q ? fill_q : rd_buf;
            mem_we    = ~rst & ~abort;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Pointers are ADDR_W wide so they wrap around the memory for free.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q     <= 1'b0;
         src_ptr    <= '0;
         dst_ptr    <= '0;
         remaining  <= '0;
         fill_q     <= '0;
         rd_buf     <= '0;
         words_done <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q     <= mode;
                  src_ptr    <= src_addr;
                  dst_ptr    <= dst_addr;
                  remaining  <= len;
                  fill_q     <= fill_value;
                  words_done <= '0;
               end
            end
            S_READ: begin
               if (!abort) begin
                  rd_buf  <= mem_rdata;
                  src_ptr <= src_ptr + ADDR_W'(1);
               end
            end
            S_WRITE: begin
               if (!abort) begin
                  dst_ptr    <= dst_ptr + ADDR_W'(1);
                  words_done <= words_done + (ADDR_W+1)'(1);
                  remaining  <= remaining - (ADDR_W+1)'(1);
               end
            end
            default: begin
               remaining <= remaining;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dma_engine.sv
// tb/tb_mem_dma_engine.sv - self-checking bench for mem_dma_engine against a word-array reference
// The reference applies each command as a forward word-by-word loop over an array.
module tb_mem_dma_engine;
   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          mode;
   logic [AW-1:0] src_addr;
   logic [AW-1:0] dst_addr;
   logic [AW:0]   len;
   logic [DW-1:0] fill_value;
   logic          abort;
   logic          busy;
   logic          done;
   logic [AW:0]   words_done;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic          seed_we;
   logic [AW-1:0] seed_addr;
   logic [DW-1:0] seed_data;

   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];

   int n_checks = 0;
   int n_fail   = 0;

   int r_busy;
   int r_done_cyc;
   int r_writes;
   int r_first_we;
   bit r_done_seen;
   bit r_aborted;
   logic r_abort_we;
   int w_addr_q[$];
   int w_cyc_q[$];

   always #5 clk = ~clk;

   mem_dma_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mode       (mode),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len        (len),
      .fill_value (fill_value),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .words_done (words_done),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else if (seed_we) mem[seed_addr] <= seed_data;
   end
   assign mem_rdata = mem[mem_addr];

   task automatic poke(input int a, input logic [DW-1:0] d);
      seed_we   = 1'b1;
      seed_addr = a[AW-1:0];
      seed_data = d;
      ref_mem[a % DEPTH] = d;
      @(posedge clk); #1;
      seed_we = 1'b0;
   endtask

   task automatic ref_cmd(input bit m, input int s, input int d, input int l, input logic [DW-1:0] f);
      for (int i = 0; i < l; i++)
         ref_mem[(d + i) % DEPTH] = m ? f : ref_mem[(s + i) % DEPTH];
   endtask

   function automatic int mem_mismatch();
      int n = 0;
      for (int i = 0; i < DEPTH; i++)
         if (mem[i] !== ref_mem[i]) n++;
      return n;
   endfunction

   task automatic run_cmd(input bit m, input int s, input int d, input int l,
                          input logic [DW-1:0] f, input int inj_cyc, input int abort_n);
      mode = m; src_addr = s[AW-1:0]; dst_addr = d[AW-1:0]; len = l[AW:0]; fill_value = f;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      r_busy = 0; r_done_seen = 0; r_done_cyc = -1; r_writes = 0; r_first_we = -1;
      r_aborted = 0; r_abort_we = 1'b1;
      w_addr_q.delete(); w_cyc_q.delete();
      for (int cyc = 0; cyc < 5000; cyc++) begin
         if (cyc == inj_cyc) begin
            start = 1'b1; mode = ~m; src_addr = AW'($urandom); dst_addr = AW'($urandom);
            len = 7; fill_value = $urandom;
            #1;
         end
         if (mem_we && abort_n > 0 && r_writes + 1 == abort_n) begin
            abort = 1'b1;
            #1;
            r_abort_we = mem_we;
            r_aborted  = 1;
            r_busy    += int'(busy);
         end else begin
            if (mem_we) begin
               if (r_first_we < 0) r_first_we = cyc;
               r_writes++;
               w_addr_q.push_back(int'(mem_addr));
               w_cyc_q.push_back(cyc);
            end
            r_busy += int'(busy);
            if (done) begin r_done_seen = 1; r_done_cyc = cyc; end
         end
         if (r_done_seen || r_aborted) break;
         @(posedge clk); #1;
         start = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if ({busy, done, mem_we} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, mem_we});
      end
      n_checks++;
      if (words_done !== '0) begin
         n_fail++; $display("FAIL reset_words_done: got %0d expected 0", words_done);
      end
      n_checks++;
      if (mem_addr !== '0 || mem_wdata !== '0) begin
         n_fail++; $display("FAIL reset_mem_bus: got addr %0h data %0h expected 0 0", mem_addr, mem_wdata);
      end
   endtask

   task automatic test_copy_basic();
      logic [DW-1:0] vals [4];
      vals[0] = 32'hAAAA_0001; vals[1] = 32'hBBBB_0002; vals[2] = 32'hCCCC_0003; vals[3] = 32'hDDDD_0004;
      for (int i = 0; i < 4; i++) poke('h10 + i, vals[i]);
      ref_cmd(0, 'h10, 'h100, 4, 0);
      run_cmd(0, 'h10, 'h100, 4, 0, -1, 0);
      n_checks++;
      if (!r_done_seen || r_busy != 8) begin
         n_fail++; $display("FAIL copy_busy: got done %0d busy %0d expected 1 8", r_done_seen, r_busy);
      end
      n_checks++;
      if (r_first_we != 1) begin
         n_fail++; $display("FAIL copy_latency: got first write cycle %0d expected 1", r_first_we);
      end
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || words_done !== 11'd4) begin
         n_fail++; $display("FAIL copy_after: got done %b busy %b words %0d expected 0 0 4", done, busy, words_done);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (mem['h100 + i] !== vals[i]) begin
            n_fail++; $display("FAIL copy_word%0d: got %h expected %h", i, mem['h100 + i], vals[i]);
         end
      end
      n_checks++;
      if (mem_mismatch() != 0) begin
         n_fail++; $display("FAIL copy_image: got %0d differing words expected 0", mem_mismatch());
      end
   endtask

   task automatic test_fill_wrap();
      logic [DW-1:0] keep;
      keep = ref_mem[1];
      ref_cmd(1, 0, 'h3FE, 3, 32'hDEADBEEF);
      run_cmd(1, 0, 'h3FE, 3, 32'hDEADBEEF, -1, 0);
      n_checks++;
      if (w_addr_q.size() != 3 || r_busy != 3 || !r_done_seen) begin
         n_fail++; $display("FAIL fill_count: got writes %0d busy %0d done %0d expected 3 3 1",
                            w_addr_q.size(), r_busy, r_done_seen);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (w_addr_q[i] != ('h3FE + i) % DEPTH || w_cyc_q[i] != i) begin
               n_fail++; $display("FAIL fill_seq%0d: got addr %0h cycle %0d expected %0h %0d",
                                  i, w_addr_q[i], w_cyc_q[i], ('h3FE + i) % DEPTH, i);
            end
         end
      end
      n_checks++;
      if (mem[1] !== keep || mem[0] !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL fill_wrap_edge: got mem0 %h mem1 %h expected deadbeef %h", mem[0], mem[1], keep);
      end
      n_checks++;
      if (mem_mismatch() != 0) begin
         n_fail++; $display("FAIL fill_image: got %0d differing words expected 0", mem_mismatch());
      end
   endtask

   task automatic test_len_zero();
      run_cmd(0, int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH-1)), 0, 0, -1, 0);
      n_checks++;
      if (r_done_cyc != 0 || r_writes != 0 || r_busy != 0) begin
         n_fail++; $display("FAIL len0: got done cycle %0d writes %0d busy %0d expected 0 0 0",
                            r_done_cyc, r_writes, r_busy);
      end
      n_checks++;
      if (words_done !== '0 || done !== 1'b0) begin
         n_fail++; $display("FAIL len0_after: got words %0d done %b expected 0 0", words_done, done);
      end
   endtask

   task automatic test_start_ignored();
      ref_cmd(0, 'h40, 'h140, 4, 0);
      run_cmd(0, 'h40, 'h140, 4, 0, 3, 0);
      n_checks++;
      if (!r_done_seen || r_busy != 8 || words_done !== 11'd4) begin
         n_fail++; $display("FAIL start_busy: got done %0d busy %0d words %0d expected 1 8 4",
                            r_done_seen, r_busy, words_done);
      end
      n_checks++;
      if (mem_mismatch() != 0) begin
         n_fail++; $display("FAIL start_busy_image: got %0d differing words expected 0", mem_mismatch());
      end
      ref_cmd(1, 0, 'h180, 2, 32'h0BAD_F00D);
      run_cmd(1, 0, 'h180, 2, 32'h0BAD_F00D, 2, 0);
      n_checks++;
      if (busy !== 1'b0 || words_done !== 11'd2) begin
         n_fail++; $display("FAIL start_in_done: got busy %b words %0d expected 0 2", busy, words_done);
      end
      n_checks++;
      if (mem_mismatch() != 0) begin
         n_fail++; $display("FAIL start_in_done_image: got %0d differing words expected 0", mem_mismatch());
      end
   endtask

   task automatic test_abort();
      int s, d;
      s = int'($urandom_range(0, DEPTH-1));
      d = int'($urandom_range(0, DEPTH-1));
      ref_cmd(0, s, d, 4, 0);
      run_cmd(0, s, d, 8, 0, -1, 5);
      n_checks++;
      if (!r_aborted || r_writes != 4 || r_abort_we !== 1'b0 || r_done_seen) begin
         n_fail++; $display("FAIL abort_cycle: got aborted %0d writes %0d we %b done %0d expected 1 4 0 0",
                            r_aborted, r_writes, r_abort_we, r_done_seen);
      end
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || words_done !== 11'd4) begin
         n_fail++; $display("FAIL abort_idle: got busy %b done %b words %0d expected 0 0 4", busy, done, words_done);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL abort_no_done: got done %b busy %b expected 0 0", done, busy);
      end
      n_checks++;
      if (mem_mismatch() != 0) begin
         n_fail++; $display("FAIL abort_image: got %0d differing words expected 0", mem_mismatch());
      end
   endtask

   task automatic test_overlap();
      poke(0, 32'h11);
      ref_cmd(0, 0, 1, 3, 0);
      run_cmd(0, 0, 1, 3, 0, -1, 0);
      for (int i = 1; i <= 3; i++) begin
         n_checks++;
         if (mem[i] !== 32'h11) begin
            n_fail++; $display("FAIL overlap_word%0d: got %h expected 00000011", i, mem[i]);
         end
      end
      n_checks++;
      if (mem_mismatch() != 0) begin
         n_fail++; $display("FAIL overlap_image: got %0d differing words expected 0", mem_mismatch());
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] v;
      v = $urandom;
      mode = 1'b1; dst_addr = 'h200; src_addr = '0; len = 5; fill_value = v; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      n_checks++;
      if (mem_we !== 1'b0) begin
         n_fail++; $display("FAIL rst_we: got %b expected 0", mem_we);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      ref_cmd(1, 0, 'h200, 2, v);
      n_checks++;
      if ({busy, done, mem_we} !== 3'b000 || words_done !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
         n_fail++; $display("FAIL rst_outputs: got flags %b words %0d addr %0h data %0h expected 000 0 0 0",
                            {busy, done, mem_we}, words_done, mem_addr, mem_wdata);
      end
      n_checks++;
      if (mem_mismatch() != 0) begin
         n_fail++; $display("FAIL rst_image: got %0d differing words expected 0", mem_mismatch());
      end
   endtask

   task automatic test_full_len();
      int d, s;
      logic [DW-1:0] v;
      v = $urandom;
      d = int'($urandom_range(0, DEPTH-1));
      ref_cmd(1, 0, d, DEPTH, v);
      run_cmd(1, 0, d, DEPTH, v, -1, 0);
      n_checks++;
      if (!r_done_seen || r_busy != DEPTH || words_done !== 11'd1024) begin
         n_fail++; $display("FAIL full_fill: got done %0d busy %0d words %0d expected 1 1024 1024",
                            r_done_seen, r_busy, words_done);
      end
      n_checks++;
      if (mem_mismatch() != 0) begin
         n_fail++; $display("FAIL full_fill_image: got %0d differing words expected 0", mem_mismatch());
      end
      for (int i = 0; i < 8; i++) poke(int'($urandom_range(0, DEPTH-1)), $urandom);
      s = int'($urandom_range(0, DEPTH-1));
      d = int'($urandom_range(0, DEPTH-1));
      ref_cmd(0, s, d, DEPTH, 0);
      run_cmd(0, s, d, DEPTH, 0, -1, 0);
      n_checks++;
      if (!r_done_seen || r_busy != 2 * DEPTH || words_done !== 11'd1024) begin
         n_fail++; $display("FAIL full_copy: got done %0d busy %0d words %0d expected 1 2048 1024",
                            r_done_seen, r_busy, words_done);
      end
      n_checks++;
      if (mem_mismatch() != 0) begin
         n_fail++; $display("FAIL full_copy_image: got %0d differing words expected 0", mem_mismatch());
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 12; k++) begin
         bit m;
         int s, d, l, eb;
         logic [DW-1:0] f;
         m = 1'($urandom);
         s = int'($urandom_range(0, DEPTH-1));
         d = int'($urandom_range(0, DEPTH-1));
         l = int'($urandom_range(0, 40));
         f = $urandom;
         eb = (l == 0) ? 0 : (m ? l : 2 * l);
         ref_cmd(m, s, d, l, f);
         run_cmd(m, s, d, l, f, -1, 0);
         n_checks++;
         if (!r_done_seen || r_busy != eb || int'(words_done) != l || r_writes != l) begin
            n_fail++; $display("FAIL b2b%0d: got done %0d busy %0d words %0d writes %0d expected 1 %0d %0d %0d",
                               k, r_done_seen, r_busy, words_done, r_writes, eb, l, l);
         end
         n_checks++;
         if (mem_mismatch() != 0) begin
            n_fail++; $display("FAIL b2b%0d_image: got %0d differing words expected 0", k, mem_mismatch());
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
      fill_value = '0; abort = 1'b0; seed_we = 1'b0; seed_addr = '0; seed_data = '0;
      test_reset();
      for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
      test_copy_basic();
      test_fill_wrap();
      test_len_zero();
      test_start_ignored();
      test_abort();
      test_overlap();
      test_reset_mid();
      test_full_len();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
